// File: rtl/axi_lite_rd_arbiter.sv
// Two-master AXI-lite read-channel arbiter (AR + R) with one outstanding transaction.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise m1 wins ties (fixed priority).
module axi_lite_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [RESP_W-1:0] m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [RESP_W-1:0] m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [RESP_W-1:0] s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   winner;
  logic   sel_arvalid;
  logic   sel_rready;

  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the master that did not own the previous transaction wins.
    if (m0_arvalid && m1_arvalid) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_arvalid;
    end
`else
    winner = m1_arvalid;
`endif
  end

  assign sel_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign sel_rready  = grant_q ? m1_rready  : m0_rready;
  assign s_araddr    = grant_q ? m1_araddr  : m0_araddr;

  // Data and response are broadcast; only the valids are steered.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    case (state_q)
      StIdle: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_d = winner;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s_arvalid  = sel_arvalid;
        m0_arready = ~grant_q & s_arready;
        m1_arready = grant_q & s_arready;
        if (sel_arvalid && s_arready) begin
          state_d = StData;
        end
      end
      StData: begin
        s_rready  = sel_rready;
        m0_rvalid = ~grant_q & s_rvalid;
        m1_rvalid = grant_q & s_rvalid;
        if (s_rvalid && sel_rready) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Scoreboard bench for axi_lite_rd_arbiter: master/slave models, expected AR and R queues.
// Tie-order expectations follow ARB_RR_EN when the bench is built with it.
module tb_axi_lite_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [RW-1:0] m0_rresp, m1_rresp, s_rresp;
  logic          m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;

  always #5 clk = ~clk;

  axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RESP_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_araddr (m0_araddr),
    .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready),
    .m0_rdata  (m0_rdata),
    .m0_rresp  (m0_rresp),
    .m0_rvalid (m0_rvalid),
    .m0_rready (m0_rready),
    .m1_araddr (m1_araddr),
    .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready),
    .m1_rdata  (m1_rdata),
    .m1_rresp  (m1_rresp),
    .m1_rvalid (m1_rvalid),
    .m1_rready (m1_rready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
  );

  typedef struct packed {
    logic          id;
    logic [RW-1:0] resp;
    logic [DW-1:0] data;
  } rbeat_t;

  logic [AW-1:0] exp_ar_q[$];
  rbeat_t        exp_r_q[$];
  logic [AW-1:0] m0_req_q[$];
  logic [AW-1:0] m1_req_q[$];
  int            ar_times[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int r_wait = 0;
  int ar_stall = 0;
  int m0_rstall = 0;
  int m1_rstall = 0;
  bit rpend = 0;
  int rcnt = 0;
  logic [AW-1:0] raddr = '0;
  bit prev_r_hs = 0;
  int m0_arrdy_cnt = 0;
  int m1_act_cnt = 0;
  int both_cnt = 0;
  int ar_hold_cnt = 0;
  int r_hold_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] slv_data(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    if (a == 32'h8000_2000) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [RW-1:0] slv_resp(input logic [AW-1:0] a);
    return (a == 32'h8000_2000) ? 2'b10 : 2'b00;
  endfunction

  task automatic apply();
    m0_arvalid = (m0_req_q.size() != 0);
    m0_araddr  = m0_arvalid ? m0_req_q[0] : '0;
    m1_arvalid = (m1_req_q.size() != 0);
    m1_araddr  = m1_arvalid ? m1_req_q[0] : '0;
    m0_rready  = (m0_rstall == 0);
    m1_rready  = (m1_rstall == 0);
    s_arready  = (ar_stall == 0);
  endtask

  task automatic req(input bit id, input logic [AW-1:0] a);
    if (id) m1_req_q.push_back(a);
    else m0_req_q.push_back(a);
    apply();
  endtask

  task automatic expect_txn(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [RW-1:0] r);
    rbeat_t b;
    b.id = id;
    b.resp = r;
    b.data = d;
    exp_ar_q.push_back(a);
    exp_r_q.push_back(b);
  endtask

  task automatic flush();
    exp_ar_q.delete();
    exp_r_q.delete();
    m0_req_q.delete();
    m1_req_q.delete();
    rpend = 0;
    s_rvalid = 1'b0;
    ar_stall = 0;
    m0_rstall = 0;
    m1_rstall = 0;
    prev_r_hs = 0;
    apply();
  endtask

  // One clock: observe and score at negedge, then advance the models just after posedge.
  task automatic cycle();
    bit ar0, ar1, sar, r0, r1, sr, sav, m0rv, m1rv;
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    rbeat_t e;
    @(negedge clk);
    cyc++;
    ar0  = m0_arvalid && m0_arready;
    ar1  = m1_arvalid && m1_arready;
    sar  = s_arvalid && s_arready;
    r0   = m0_rvalid && m0_rready;
    r1   = m1_rvalid && m1_rready;
    sr   = s_rvalid && s_rready;
    sav  = s_arvalid;
    m0rv = m0_rvalid;
    m1rv = m1_rvalid;
    sa   = s_araddr;
    if (prev_r_hs) begin
      check_eq("idle_after_r", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid,
                                m1_rvalid}, 0);
    end
    if (m0_arready) m0_arrdy_cnt++;
    if (m1_arready || m1_rvalid) m1_act_cnt++;
    if ((m0_arready && m1_arready) || (m0_rvalid && m1_rvalid)) both_cnt++;
    if (s_arvalid && !s_arready) begin
      ar_hold_cnt++;
      if (exp_ar_q.size() != 0) check_eq("ar_hold_addr", s_araddr, exp_ar_q[0]);
    end
    if (m0_rvalid && !m0_rready) begin
      r_hold_cnt++;
      check_eq("rready_hold", s_rready, 0);
    end
    if (sar) begin
      ar_times.push_back(cyc);
      check_eq("ar_expected", exp_ar_q.size() != 0, 1);
      if (exp_ar_q.size() != 0) begin
        ea = exp_ar_q.pop_front();
        check_eq("s_araddr", sa, ea);
      end
      if (exp_r_q.size() != 0) check_eq("ar_owner", {ar1, ar0}, exp_r_q[0].id ? 2'b10 : 2'b01);
    end
    if (sr || r0 || r1) begin
      check_eq("r_hs_match", {sr, r0 | r1}, 2'b11);
      check_eq("bus_m0", {m0_rresp, m0_rdata}, {s_rresp, s_rdata});
      check_eq("bus_m1", {m1_rresp, m1_rdata}, {s_rresp, s_rdata});
      check_eq("r_expected", exp_r_q.size() != 0, 1);
      if (exp_r_q.size() != 0) begin
        e = exp_r_q.pop_front();
        check_eq("r_beat", r0 ? {1'b0, m0_rresp, m0_rdata} : {1'b1, m1_rresp, m1_rdata}, e);
      end
    end
    prev_r_hs = sr;
    @(posedge clk);
    #1;
    if (ar0) void'(m0_req_q.pop_front());
    if (ar1) void'(m1_req_q.pop_front());
    if (sav && ar_stall > 0) ar_stall--;
    if (m0rv && m0_rstall > 0) m0_rstall--;
    if (m1rv && m1_rstall > 0) m1_rstall--;
    if (sr) begin
      s_rvalid = 1'b0;
      rpend = 0;
    end
    if (sar) begin
      rpend = 1;
      rcnt = r_wait;
      raddr = sa;
    end
    if (rpend && !s_rvalid) begin
      if (rcnt == 0) begin
        s_rvalid = 1'b1;
        s_rdata  = slv_data(raddr);
        s_rresp  = slv_resp(raddr);
      end else begin
        rcnt--;
      end
    end
    apply();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_ar_q.size() + exp_r_q.size() + m0_req_q.size() + m1_req_q.size() + int'(rpend))
           != 0 && n < max) begin
      cycle();
      n++;
    end
    check_eq("drain_pending", exp_ar_q.size() + exp_r_q.size() + m0_req_q.size() +
             m1_req_q.size() + int'(rpend), 0);
    cycle();
    flush();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    repeat (2) cycle();
    check_eq("reset_outs", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid},
             0);
    rst_n = 1'b1;
  endtask

  initial begin
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = '0;
    apply();
    do_reset();

    // Single IFU read with two slave wait cycles.
    r_wait = 2;
    m0_arrdy_cnt = 0;
    m1_act_cnt = 0;
    req(0, 32'h8000_0000);
    expect_txn(0, 32'h8000_0000, 32'h0000_0413, 2'b00);
    drain(50);
    check_eq("t1_m0_arready_pulses", m0_arrdy_cnt, 1);
    check_eq("t1_m1_quiet", m1_act_cnt, 0);

    // Error response routed to the LSU.
    r_wait = 1;
    req(1, 32'h8000_2000);
    expect_txn(1, 32'h8000_2000, 32'hDEAD_BEEF, 2'b10);
    drain(50);

    // Tie from a freshly reset arbiter.
    do_reset();
    r_wait = 1;
`ifdef ARB_RR_EN
    req(0, 32'h8000_0004);
    req(0, 32'h8000_0004);
    req(1, 32'h8000_1000);
    expect_txn(0, 32'h8000_0004, slv_data(32'h8000_0004), 2'b00);
    expect_txn(1, 32'h8000_1000, slv_data(32'h8000_1000), 2'b00);
    expect_txn(0, 32'h8000_0004, slv_data(32'h8000_0004), 2'b00);
`else
    req(0, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      req(1, 32'h8000_1000);
      expect_txn(1, 32'h8000_1000, slv_data(32'h8000_1000), 2'b00);
    end
    expect_txn(0, 32'h8000_0004, slv_data(32'h8000_0004), 2'b00);
`endif
    drain(100);

    // Backpressure on AR then on R.
    r_wait = 0;
    ar_hold_cnt = 0;
    r_hold_cnt = 0;
    ar_stall = 4;
    m0_rstall = 3;
    req(0, 32'h8000_0008);
    expect_txn(0, 32'h8000_0008, slv_data(32'h8000_0008), 2'b00);
    drain(50);
    check_eq("ar_hold_cycles", ar_hold_cnt, 4);
    check_eq("r_hold_cycles", r_hold_cnt, 3);

    // Zero-wait back-to-back transactions take three cycles each.
    ar_times.delete();
    for (int i = 0; i < 3; i++) begin
      req(0, 32'h8000_0010 + 32'(4 * i));
      expect_txn(0, 32'h8000_0010 + 32'(4 * i), slv_data(32'h8000_0010 + 32'(4 * i)), 2'b00);
    end
    drain(50);
    check_eq("b2b_count", ar_times.size(), 3);
    if (ar_times.size() == 3) begin
      check_eq("b2b_gap0", ar_times[1] - ar_times[0], 3);
      check_eq("b2b_gap1", ar_times[2] - ar_times[1], 3);
    end

    // Reset while stalled in DATA with slave and LSU still asserting.
    r_wait = 1;
    m0_rstall = 50;
    req(0, 32'h8000_0020);
    expect_txn(0, 32'h8000_0020, slv_data(32'h8000_0020), 2'b00);
    for (int i = 0; i < 20 && !m0_rvalid; i++) cycle();
    check_eq("reached_data", m0_rvalid, 1);
    req(1, 32'h8000_0030);
    rst_n = 1'b0;
    cycle();
    @(negedge clk);
    check_eq("rst_mid_outs", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid},
             0);
    @(posedge clk);
    #1;
    flush();
    rst_n = 1'b1;
    req(0, 32'h8000_0024);
    expect_txn(0, 32'h8000_0024, slv_data(32'h8000_0024), 2'b00);
    drain(50);

    check_eq("exclusive_grant", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master, one-slave AXI-lite read-channel arbiter (AR + R only).
- Shares the single instruction/data SRAM slave between the IFU read port (m0) and the LSU read port (m1).
- One outstanding transaction total; grant is locked from AR handshake until R handshake.
- LSU write channels bypass this block.

Parameters:
ADDR_W, 32, AXI-lite address width
DATA_W, 32, AXI-lite data width
RESP_W, 2, rresp width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
m{0,1}_araddr  input  ADDR_W  per-master read address
m{0,1}_arvalid  input  1  per-master read request valid
m{0,1}_arready  output  1  per-master address accepted
m{0,1}_rdata  output  DATA_W  read data to master
m{0,1}_rresp  output  RESP_W  read response to master
m{0,1}_rvalid  output  1  read data valid to master
m{0,1}_rready  input  1  master ready for data
s_araddr  output  ADDR_W  address to slave
s_arvalid  output  1  request valid to slave
s_arready  input  1  slave address accepted
s_rdata  input  DATA_W  slave read data
s_rresp  input  RESP_W  slave read response
s_rvalid  input  1  slave data valid
s_rready  output  1  ready to slave

Behaviour:
- Clock and reset: clk, rising edge; rst_n is a synchronous, active-low reset.
- Registers: state (2b), grant (1b, index of owning master), last_grant (1b).
- State IDLE:
  - No master is forwarded. s_arvalid=0, s_rready=0, all m*_arready=0, all m*_rvalid=0.
  - If any m*_arvalid is high: grant <= winner, next state ADDR.
  - Arbitration takes one cycle; no combinational path from m*_arvalid to s_arvalid in IDLE.
- State ADDR:
  - Forwarded to slave: s_araddr=m[grant]_araddr, s_arvalid=m[grant]_arvalid.
  - Returned to owner: m[grant]_arready=s_arready.
  - On s_arvalid && s_arready: next state DATA.
  - If the granted master drops arvalid (illegal per AXI): stay in ADDR, s_arvalid=0.
- State DATA:
  - m[grant]_rvalid=s_rvalid; s_rready=m[grant]_rready.
  - On s_rvalid && s_rready: next state IDLE, last_grant <= grant.
  - s_arvalid=0 throughout.
- Shared data bus: m0_rdata=m1_rdata=s_rdata and m0_rresp=m1_rresp=s_rresp at all times. Only the valid signals are gated.
- Non-granted master: arready=0 and rvalid=0 in every state; its arvalid stays pending and is not dropped.
- Minimum transaction (zero-wait slave, masters always ready):
  - IDLE→ADDR→DATA→IDLE, i.e. 3 cycles per transaction, back-to-back.
  - AR handshake in cycle 1 after request; R handshake no earlier than cycle 2.
- Simultaneous requests in IDLE: resolved per the policy under Optional Feature.
- A request arriving in the same cycle an R handshake completes is seen in the following IDLE cycle.
- Reset (including mid-transaction):
  - state=IDLE, grant=0, last_grant=1.
  - All outputs as in IDLE on the next edge.
  - The in-flight transaction is abandoned; the slave and masters are reset on the same rst_n.
- Unreachable state encoding: forced to IDLE next cycle.
- rresp is passed through unmodified (including SLVERR/DECERR).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. The winner on a tie is the master not equal to last_grant. With last_grant reset to 1, m0 (IFU) wins the first tie; tied requesters then alternate.
- Undefined: fixed priority, m1 (LSU) always wins ties. last_grant is still updated but unused for the decision. m0 may starve while m1 requests continuously; this is accepted.
- A single requester is always granted regardless of mode.

Test Plan:
- Single IFU read: m0 araddr=0x8000_0000, slave returns rdata=0x0000_0413, rresp=0 after 2 wait cycles.
  - Required: m0_arready pulses once, m0_rvalid with rdata=0x0000_0413.
  - Required: m1_arready=0 and m1_rvalid=0 throughout; back in IDLE one cycle after R handshake.
- Tie, ARB_RR_EN defined: m0 araddr=0x8000_0004 and m1 araddr=0x8000_1000 both valid from the same cycle and held.
  - Required: s_araddr sequence is 0x8000_0004, then 0x8000_1000, then 0x8000_0004 (m0 re-requests).
- Tie, ARB_RR_EN undefined: same stimulus with m1 held valid for 3 transactions.
  - Required: s_araddr=0x8000_1000 three times before any 0x8000_0004.
- Backpressure:
  - s_arready held 0 for 4 cycles: s_arvalid stays 1 and s_araddr stays stable.
  - Then m0_rready held 0 for 3 cycles with s_rvalid=1: s_rready=0 and state stays DATA; completes when m0_rready=1.
- Reset mid-operation: assert rst_n=0 while in DATA.
  - Required: next cycle all m*_arready, m*_rvalid, s_arvalid, s_rready = 0.
  - Required: after release, a fresh m0 request is granted normally.
- Error passthrough: slave returns rresp=2'b10, rdata=0xDEAD_BEEF to m1.
  - Required: m1 sees rresp=2'b10 and rdata=0xDEAD_BEEF; arbiter returns to IDLE normally.
